// File: rtl/act_pwl_pipe.sv
// Pipelined piecewise-linear tanh/sigmoid: sign/abs -> segment -> output, with sideband tag and sat flag.
// Latency 3 cycles, 1/cycle; all stages stall together when the output is held (i_ready = o_ready | ~o_valid).
module act_pwl_pipe #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 24,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_mode,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_sat
);

  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1) << FRAC;
  localparam logic [WIDTH-1:0] B0    = WIDTH'(1) << (FRAC - 2);
  localparam logic [WIDTH-1:0] B2    = WIDTH'(5) << (FRAC - 1);
  localparam logic [WIDTH-1:0] C0    = WIDTH'(3) << (FRAC - 5);
  localparam logic [WIDTH-1:0] C1    = WIDTH'(17) << (FRAC - 5);
  localparam logic [WIDTH-1:0] MAXP  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINN  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef struct packed {
    logic             s;
    logic [WIDTH-1:0] a;
    logic             mode;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic             s;
    logic [WIDTH-1:0] m;
    logic             mode;
    logic             sat;
    logic [TAG_W-1:0] tag;
  } s2_t;

  logic             adv;
  logic             s1_vld, s2_vld;
  s1_t              s1_q, s1_nxt;
  s2_t              s2_q, s2_nxt;
  logic [WIDTH-1:0] u;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] y_nxt;

  assign adv     = o_ready | ~o_valid;
  assign i_ready = adv;

  // Sigmoid(x) is evaluated as (tanh(x/2) + 1) / 2, so the halving happens up front.
  always_comb begin
    u           = i_mode ? WIDTH'($signed(i_data) >>> 1) : i_data;
    s1_nxt.s    = u[WIDTH-1];
    s1_nxt.mode = i_mode;
    s1_nxt.tag  = i_tag;
    if (u == MINN)
      s1_nxt.a = MAXP;
    else if (u[WIDTH-1])
      s1_nxt.a = -u;
    else
      s1_nxt.a = u;
  end

  always_comb begin
    s2_nxt.s    = s1_q.s;
    s2_nxt.mode = s1_q.mode;
    s2_nxt.tag  = s1_q.tag;
    s2_nxt.sat  = 1'b0;
    if (s1_q.a < B0) begin
      s2_nxt.m = s1_q.a;
    end else if (s1_q.a < ONE) begin
      s2_nxt.m = (s1_q.a >> 1) + (s1_q.a >> 3) + C0;
    end else if (s1_q.a < B2) begin
      s2_nxt.m = (s1_q.a >> 3) + (s1_q.a >> 4) + C1;
    end else begin
      s2_nxt.m   = ONE;
      s2_nxt.sat = 1'b1;
    end
  end

  // t + ONE is never negative and never exceeds 2*ONE, so a logical shift is exact.
  always_comb begin
    t     = s2_q.s ? -s2_q.m : s2_q.m;
    y_nxt = s2_q.mode ? ((t + ONE) >> 1) : t;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_q    <= '0;
      s2_vld  <= 1'b0;
      s2_q    <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_tag   <= '0;
      o_sat   <= 1'b0;
    end else if (adv) begin
      s1_vld  <= i_valid;
      s1_q    <= s1_nxt;
      s2_vld  <= s1_vld;
      s2_q    <= s2_nxt;
      o_valid <= s2_vld;
      o_data  <= y_nxt;
      o_tag   <= s2_q.tag;
      o_sat   <= s2_q.sat;
    end
  end

endmodule

// File: tb/tb_act_pwl_pipe.sv
// Bench for act_pwl_pipe: directed literal cases, backpressure, mid-stream reset, random traffic vs. model.
module tb_act_pwl_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic        i_ready;
  logic [31:0] i_data;
  logic        i_mode;
  logic [3:0]  i_tag;
  logic        o_valid;
  logic        o_ready;
  logic [31:0] o_data;
  logic [3:0]  o_tag;
  logic        o_sat;

  always #5 clk = ~clk;

  act_pwl_pipe #(.WIDTH(32), .FRAC(24), .TAG_W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_data  (i_data),
    .i_mode  (i_mode),
    .i_tag   (i_tag),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_tag   (o_tag),
    .o_sat   (o_sat)
  );

  int checks   = 0;
  int failures = 0;
  int n_out    = 0;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  tag;
    logic        sat;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on real-valued breakpoints, Q8.24.
  function automatic logic [32:0] model(input logic [31:0] x, input logic md);
    longint one, xs, u, a, m, t, y;
    logic   sat;
    one = 64'sd1 << 24;
    xs  = longint'($signed(x));
    u   = md ? (xs >>> 1) : xs;
    a   = (u < 0) ? -u : u;
    if (a > 64'sd2147483647) a = 64'sd2147483647;
    sat = 1'b0;
    if (a < one / 4)          m = a;
    else if (a < one)         m = a / 2 + a / 8 + 3 * (one / 32);
    else if (a < 5 * one / 2) m = a / 8 + a / 16 + 17 * (one / 32);
    else begin
      m   = one;
      sat = 1'b1;
    end
    t = (u < 0) ? -m : m;
    y = md ? ((t + one) >>> 1) : t;
    return {sat, y[31:0]};
  endfunction

  // Scoreboard: everything is stable at the falling edge, so transfers seen here happen on the next rising edge.
  always @(negedge clk) begin
    exp_t        e;
    logic [32:0] r;
    if (!rst_n) begin
      q.delete();
    end else begin
      if (o_valid && !o_ready) chk("stall_iready", {31'b0, i_ready}, 32'd0);
      if (o_valid && o_ready) begin
        n_out++;
        if (q.size() == 0) begin
          chk("unexpected_out", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("sb_data", o_data, e.d);
          chk("sb_tag", {28'b0, o_tag}, {28'b0, e.tag});
          chk("sb_sat", {31'b0, o_sat}, {31'b0, e.sat});
        end
      end
      if (i_valid && i_ready) begin
        r     = model(i_data, i_mode);
        e.d   = r[31:0];
        e.sat = r[32];
        e.tag = i_tag;
        q.push_back(e);
      end
    end
  end

  task automatic directed(input string nm, input logic [31:0] x, input logic md,
                          input logic [31:0] ey, input logic es);
    logic [32:0] r;
    int          lat;
    r = model(x, md);
    chk({nm, "_model_y"}, r[31:0], ey);
    chk({nm, "_model_sat"}, {31'b0, r[32]}, {31'b0, es});
    @(posedge clk); #1;
    i_valid = 1'b1;
    i_data  = x;
    i_mode  = md;
    i_tag   = 4'(x[3:0] ^ 4'h5);
    @(posedge clk); #1;
    i_valid = 1'b0;
    lat     = 1;
    while (!o_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_latency"}, lat, 32'd3);
    chk({nm, "_y"}, o_data, ey);
    chk({nm, "_sat"}, {31'b0, o_sat}, {31'b0, es});
  endtask

  function automatic logic [31:0] rand_x();
    logic [31:0] v;
    logic [31:0] bp;
    case ($urandom_range(0, 3))
      0: v = $urandom;
      1: v = $urandom_range(0, 32'h0300_0000);
      2: begin
        case ($urandom_range(0, 5))
          0: bp = 32'h0040_0000;
          1: bp = 32'h0100_0000;
          2: bp = 32'h0280_0000;
          3: bp = 32'h0080_0000;
          4: bp = 32'h0200_0000;
          default: bp = 32'h0500_0000;
        endcase
        v = bp + $urandom_range(0, 4) - 32'd2;
      end
      default: begin
        case ($urandom_range(0, 3))
          0: v = 32'h8000_0000;
          1: v = 32'h7FFF_FFFF;
          2: v = 32'h8000_0001;
          default: v = 32'h0000_0000;
        endcase
      end
    endcase
    if ($urandom_range(0, 1) == 1) v = -v;
    return v;
  endfunction

  initial begin
    #500us;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int  sent, base;
    logic took;
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    i_mode  = 1'b0;
    i_tag   = '0;
    o_ready = 1'b1;
    #1;
    chk("rst_o_valid", {31'b0, o_valid}, 32'd0);
    chk("rst_o_data", o_data, 32'd0);
    chk("rst_o_tag", {28'b0, o_tag}, 32'd0);
    chk("rst_o_sat", {31'b0, o_sat}, 32'd0);
    chk("rst_i_ready", {31'b0, i_ready}, 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    directed("tanh_0p5",    32'h0080_0000, 1'b0, 32'h0068_0000, 1'b0);
    directed("tanh_0p125",  32'h0020_0000, 1'b0, 32'h0020_0000, 1'b0);
    directed("tanh_m1",     32'hFF00_0000, 1'b0, 32'hFF48_0000, 1'b0);
    directed("tanh_3",      32'h0300_0000, 1'b0, 32'h0100_0000, 1'b1);
    directed("tanh_minneg", 32'h8000_0000, 1'b0, 32'hFF00_0000, 1'b1);
    directed("sig_0",       32'h0000_0000, 1'b1, 32'h0080_0000, 1'b0);
    directed("sig_2",       32'h0200_0000, 1'b1, 32'h00DC_0000, 1'b0);
    directed("sig_m6",      32'hFA00_0000, 1'b1, 32'h0000_0000, 1'b1);
    directed("bp0",         32'h0040_0000, 1'b0, 32'h0040_0000, 1'b0);
    directed("bp0_m1",      32'h003F_FFFF, 1'b0, 32'h003F_FFFF, 1'b0);
    directed("bp1",         32'h0100_0000, 1'b0, 32'h00B8_0000, 1'b0);
    directed("bp1_m1",      32'h00FF_FFFF, 1'b0, 32'h00B7_FFFE, 1'b0);
    directed("bp2",         32'h0280_0000, 1'b0, 32'h0100_0000, 1'b1);
    directed("bp2_m1",      32'h027F_FFFF, 1'b0, 32'h00FF_FFFE, 1'b0);
    directed("neg_bp1_m1",  32'hFF00_0001, 1'b0, 32'hFF48_0002, 1'b0);
    repeat (4) @(posedge clk);
    #1;

    // Backpressure: 8 tagged samples, output held off during cycles 4..7.
    base = n_out;
    sent = 0;
    i_data = rand_x(); i_mode = 1'($urandom_range(0, 1)); i_tag = 4'd0;
    for (int c = 0; c < 16; c++) begin
      o_ready = !(c >= 4 && c <= 7);
      i_valid = (sent < 8);
      @(negedge clk);
      took = i_valid && i_ready;
      if (c >= 8 && c <= 14) chk("bp_rate", {31'b0, o_valid}, 32'd1);
      @(posedge clk); #1;
      if (took) begin
        sent++;
        i_data = rand_x();
        i_mode = 1'($urandom_range(0, 1));
        i_tag  = 4'(sent);
      end
    end
    i_valid = 1'b0;
    o_ready = 1'b1;
    chk("bp_count", n_out - base, 32'd8);
    repeat (3) @(posedge clk);
    #1;

    // Reset with three samples in flight and one held at the output.
    o_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_valid = 1'b1;
      i_data  = 32'h0080_0000 + 32'(k);
      i_mode  = 1'b0;
      i_tag   = 4'(k + 9);
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    chk("pre_rst_o_valid", {31'b0, o_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_o_valid", {31'b0, o_valid}, 32'd0);
    chk("mid_rst_o_data", o_data, 32'd0);
    chk("mid_rst_o_tag", {28'b0, o_tag}, 32'd0);
    chk("mid_rst_o_sat", {31'b0, o_sat}, 32'd0);
    chk("mid_rst_i_ready", {31'b0, i_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    o_ready = 1'b1;
    directed("post_rst", 32'hFF80_0000, 1'b0, 32'hFF98_0000, 1'b0);
    repeat (4) @(posedge clk);
    #1;

    // Random traffic with random backpressure; payload only changes after acceptance.
    i_valid = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      o_ready = ($urandom_range(0, 3) != 0);
      if (!i_valid) begin
        i_valid = ($urandom_range(0, 3) != 0);
        i_data  = rand_x();
        i_mode  = 1'($urandom_range(0, 1));
        i_tag   = 4'($urandom);
      end
      @(negedge clk);
      took = i_valid && i_ready;
      @(posedge clk); #1;
      if (took) i_valid = 1'b0;
    end
    i_valid = 1'b0;
    o_ready = 1'b1;
    for (int w = 0; w < 20 && q.size() != 0; w++) @(posedge clk);
    #1;
    chk("drain_empty", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
